// File: rtl/mac_sequencer_if.sv
// Layer-controller, buffer, mac and write-back signals of one mac_sequencer.
// master = the sequencer, slave = the blocks around it.
interface mac_sequencer_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 6,
    parameter int CNT_WIDTH  = 8
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  cfg_kernel_len;
    logic [CNT_WIDTH-1:0]  cfg_num_out;
    logic [ADDR_WIDTH-1:0] cfg_neuron_base;
    logic [ADDR_WIDTH-1:0] cfg_weight_base;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] neuron_addr;
    logic [ADDR_WIDTH-1:0] weight_addr;
    logic                  mac_en;
    logic                  stage_finish;
    logic                  out_valid;
    logic                  out_ready;
    logic [CNT_WIDTH-1:0]  out_index;
    logic                  busy;
    logic                  done;
    logic                  cfg_err;

    modport master (
        input  start, cfg_kernel_len, cfg_num_out, cfg_neuron_base, cfg_weight_base, out_ready,
        output rd_en, neuron_addr, weight_addr, mac_en, stage_finish,
               out_valid, out_index, busy, done, cfg_err
    );

    modport slave (
        output start, cfg_kernel_len, cfg_num_out, cfg_neuron_base, cfg_weight_base, out_ready,
        input  rd_en, neuron_addr, weight_addr, mac_en, stage_finish,
               out_valid, out_index, busy, done, cfg_err
    );
endinterface

// File: rtl/mac_sequencer.sv
// Sequences one mac through a layer: streams L products per output, drains the
// mac pipeline, hands the sum to write-back, then clears the accumulator.
module mac_sequencer #(
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 6,
    parameter int CNT_WIDTH  = 8
) (
    input  logic            clk,
    input  logic            layer_reset_n,
    mac_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, HOLD, FIN} state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  num_q;
    logic [ADDR_WIDTH-1:0] wbase_q;
    logic [LEN_WIDTH-1:0]  k_q;
    logic                  drain_q;

    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] neuron_addr;
    logic [ADDR_WIDTH-1:0] weight_addr;
    logic                  mac_en;
    logic                  stage_finish;
    logic                  out_valid;
    logic [CNT_WIDTH-1:0]  out_index;
    logic                  busy;
    logic                  done;
    logic                  cfg_err;

    always_ff @(posedge clk or negedge layer_reset_n) begin
        if (!layer_reset_n) begin
            state        <= IDLE;
            len_q        <= '0;
            num_q        <= '0;
            wbase_q      <= '0;
            k_q          <= '0;
            drain_q      <= 1'b0;
            rd_en        <= 1'b0;
            neuron_addr  <= '0;
            weight_addr  <= '0;
            mac_en       <= 1'b0;
            stage_finish <= 1'b0;
            out_valid    <= 1'b0;
            out_index    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            stage_finish <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
            // buffer data arrives one cycle after the read, so the mac follows rd_en
            mac_en       <= rd_en;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.cfg_kernel_len == '0 || bus.cfg_num_out == '0) begin
                            cfg_err <= 1'b1;
                        end else begin
                            len_q       <= bus.cfg_kernel_len;
                            num_q       <= bus.cfg_num_out;
                            wbase_q     <= bus.cfg_weight_base;
                            neuron_addr <= bus.cfg_neuron_base;
                            weight_addr <= bus.cfg_weight_base;
                            out_index   <= '0;
                            k_q         <= '0;
                            rd_en       <= 1'b1;
                            busy        <= 1'b1;
                            state       <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (k_q == len_q - 1'b1) begin
                        rd_en   <= 1'b0;
                        drain_q <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        k_q         <= k_q + 1'b1;
                        neuron_addr <= neuron_addr + 1'b1;
                        weight_addr <= weight_addr + 1'b1;
                    end
                end
                // two cycles: multiplier register, then adder register
                DRAIN: begin
                    if (drain_q) begin
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid    <= 1'b0;
                        stage_finish <= 1'b1;
                        if (out_index == num_q - 1'b1) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            // neuron pointer runs on across outputs; weights restart
                            out_index   <= out_index + 1'b1;
                            neuron_addr <= neuron_addr + 1'b1;
                            weight_addr <= wbase_q;
                            k_q         <= '0;
                            rd_en       <= 1'b1;
                            state       <= RUN;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_en        = rd_en;
    assign bus.neuron_addr  = neuron_addr;
    assign bus.weight_addr  = weight_addr;
    assign bus.mac_en       = mac_en;
    assign bus.stage_finish = stage_finish;
    assign bus.out_valid    = out_valid;
    assign bus.out_index    = out_index;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.cfg_err      = cfg_err;
endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: stimulus queues expected reads and
// handshakes, a negedge monitor pops and compares them.
module tb_mac_sequencer;
    typedef struct packed {
        logic [9:0] n;
        logic [9:0] w;
    } addr_t;

    logic clk = 1'b0;
    logic layer_reset_n = 1'b0;
    always #5 clk = ~clk;

    mac_sequencer_if bus ();
    mac_sequencer dut (.clk(clk), .layer_reset_n(layer_reset_n), .bus(bus));

    int checks = 0;
    int failures = 0;
    addr_t exp_addr[$];
    int    exp_idx[$];
    int cur_l = 1, cur_n = 1;
    int cyc = 0;
    int mac_cnt = 0, sf_cnt = 0, done_cnt = 0, err_cnt = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // monitor
    bit p_rd = 0, p_vld = 0, p_hs = 0;
    int p_idx = 0, rd_rise = 0;
    always @(negedge clk) begin
        if (!layer_reset_n) begin
            p_rd = 0; p_vld = 0; p_hs = 0; p_idx = 0;
        end else begin
            if (bus.rd_en) begin
                if (!p_rd) rd_rise = cyc;
                if (exp_addr.size() == 0) chk("unexpected_rd", 1, 0);
                else begin
                    addr_t e;
                    e = exp_addr.pop_front();
                    chk("neuron_addr", int'(bus.neuron_addr), int'(e.n));
                    chk("weight_addr", int'(bus.weight_addr), int'(e.w));
                end
            end
            if (bus.mac_en || p_rd) chk("mac_en_align", int'(bus.mac_en), int'(p_rd));
            if (bus.mac_en) mac_cnt++;
            if (bus.out_valid && !p_vld) chk("valid_latency", cyc - rd_rise, cur_l + 2);
            if (p_vld && !p_hs)
                chk("hold_stable", {bus.out_valid, bus.rd_en, bus.mac_en, bus.out_index},
                    {1'b1, 1'b0, 1'b0, 8'(p_idx)});
            if (bus.stage_finish || p_hs) chk("stage_finish", int'(bus.stage_finish), int'(p_hs));
            if (bus.stage_finish) sf_cnt++;
            if (bus.done || (p_hs && p_idx == cur_n - 1))
                chk("done", int'(bus.done), int'(p_hs && p_idx == cur_n - 1));
            if (bus.done) done_cnt++;
            if (bus.cfg_err) err_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_idx.size() == 0) chk("unexpected_hs", 1, 0);
                else chk("out_index", int'(bus.out_index), exp_idx.pop_front());
            end
            p_hs  = bus.out_valid && bus.out_ready;
            p_vld = bus.out_valid;
            p_rd  = bus.rd_en;
            p_idx = int'(bus.out_index);
        end
    end

    task automatic push_layer(input int l, input int n, input int nb, input int wb);
        for (int o = 0; o < n; o++) begin
            for (int k = 0; k < l; k++) begin
                addr_t e;
                e.n = 10'((nb + o * l + k) & 'h3FF);
                e.w = 10'((wb + k) & 'h3FF);
                exp_addr.push_back(e);
            end
            exp_idx.push_back(o);
        end
    endtask

    task automatic do_start(input int l, input int n, input int nb, input int wb, input bit track);
        if (track) begin cur_l = l; cur_n = n; end
        bus.cfg_kernel_len  = 6'(l);
        bus.cfg_num_out     = 8'(n);
        bus.cfg_neuron_base = 10'(nb);
        bus.cfg_weight_base = 10'(wb);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (bus.done) break;
        end
        if (i == bound) chk("timeout_done", 0, 1);
    endtask

    task automatic wait_valid(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) break;
        end
        if (i == bound) chk("timeout_valid", 0, 1);
    endtask

    task automatic wait_run_idx(input int idx, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (bus.rd_en && int'(bus.out_index) == idx) break;
        end
        if (i == bound) chk("timeout_run_idx", 0, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, {bus.rd_en, bus.mac_en, bus.stage_finish, bus.out_valid,
                              bus.busy, bus.done, bus.cfg_err}, 0);
        chk({tag, "_addr"}, {bus.neuron_addr, bus.weight_addr}, 0);
        chk({tag, "_idx"}, int'(bus.out_index), 0);
    endtask

    initial begin
        int m0, s0, d0, e0;
        bus.start = 1'b0;
        bus.cfg_kernel_len = '0;
        bus.cfg_num_out = '0;
        bus.cfg_neuron_base = '0;
        bus.cfg_weight_base = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        layer_reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: basic layer
        push_layer(9, 2, 0, 'h100);
        m0 = mac_cnt; d0 = done_cnt;
        do_start(9, 2, 0, 'h100, 1);
        chk("busy_run", int'(bus.busy), 1);
        wait_done(200);
        @(posedge clk); #1;
        chk("t1_idle", {bus.busy, bus.rd_en, bus.out_valid}, 0);
        chk("t1_mac_cnt", mac_cnt - m0, 18);
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_q_empty", exp_addr.size() + exp_idx.size(), 0);

        // 2: back-pressure
        bus.out_ready = 1'b0;
        push_layer(4, 1, 'h20, 'h40);
        s0 = sf_cnt; d0 = done_cnt;
        do_start(4, 1, 'h20, 'h40, 1);
        wait_valid(50);
        repeat (20) begin @(posedge clk); #1; end
        chk("t2_held", {bus.out_valid, bus.out_index}, {1'b1, 8'd0});
        chk("t2_no_sf", sf_cnt - s0, 0);
        bus.out_ready = 1'b1;
        wait_done(20);
        @(posedge clk); #1;
        chk("t2_sf_cnt", sf_cnt - s0, 1);
        chk("t2_done_cnt", done_cnt - d0, 1);

        // 3: config errors
        e0 = err_cnt;
        do_start(0, 3, 5, 5, 0);
        chk("t3_err_l0", {bus.cfg_err, bus.busy}, 2'b10);
        @(posedge clk); #1;
        chk("t3_err_pulse", int'(bus.cfg_err), 0);
        do_start(5, 0, 5, 5, 0);
        chk("t3_err_n0", {bus.cfg_err, bus.busy}, 2'b10);
        repeat (3) begin @(posedge clk); #1; end
        chk("t3_err_cnt", err_cnt - e0, 2);
        chk("t3_idle", {bus.busy, bus.rd_en}, 0);

        // 4: start while busy, then reset mid-run
        push_layer(3, 6, 'h10, 'h200);
        do_start(3, 6, 'h10, 'h200, 1);
        wait_run_idx(1, 100);
        do_start(7, 1, 'h80, 'h90, 0);
        chk("t4_still_busy", int'(bus.busy), 1);
        wait_run_idx(3, 100);
        layer_reset_n = 1'b0;
        #1;
        chk_zero("t4_midreset");
        exp_addr.delete();
        exp_idx.delete();
        @(posedge clk); #1;
        layer_reset_n = 1'b1;
        @(posedge clk); #1;
        push_layer(2, 1, 'h50, 'h60);
        d0 = done_cnt;
        do_start(2, 1, 'h50, 'h60, 1);
        wait_done(50);
        @(posedge clk); #1;
        chk("t4_done_cnt", done_cnt - d0, 1);
        chk("t4_q_empty", exp_addr.size() + exp_idx.size(), 0);

        // 5: L=1, N=255, wrapping bases
        push_layer(1, 255, 'h3FF, 'h3FF);
        m0 = mac_cnt;
        do_start(1, 255, 'h3FF, 'h3FF, 1);
        wait_done(3000);
        chk("t5_last_idx", int'(bus.out_index), 254);
        @(posedge clk); #1;
        chk("t5_mac_cnt", mac_cnt - m0, 255);
        chk("t5_q_empty", exp_addr.size() + exp_idx.size(), 0);
        chk("t5_idle", int'(bus.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
